// File: rtl/cpu_mc.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK CPU core with 2R1W register file.
// Latency: 4 cycles per instruction, plus one per FETCH cycle with IMEM_BUSY high.
// Backpressure: IMEM_BUSY holds the core in FETCH. Optional CPU_MC_MUL_EN adds opcode 0x08 MUL.
module cpu_mc #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [31:0]           PC,
    input  logic [31:0]           INSTRUCTION,
    output logic                  IMEM_READ,
    input  logic                  IMEM_BUSY,
    output logic                  RETIRE,
    output logic                  WB_EN,
    output logic [REG_ADDR_W-1:0] WB_ADDR,
    output logic [DATA_W-1:0]     WB_DATA,
    output logic                  ILLEGAL
);

    localparam int NREGS = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0]           pc;
    logic [31:0]           ir;
    logic [31:0]           npc_q;
    logic [31:0]           npc_c;
    logic [DATA_W-1:0]     regs [NREGS];
    logic [DATA_W-1:0]     opa;
    logic [DATA_W-1:0]     opb;
    logic [DATA_W-1:0]     res_q;
    logic [DATA_W-1:0]     res_c;
    logic                  wr_q;
    logic                  wr_c;
    logic                  ill_q;
    logic                  ill_c;

    logic [7:0]            opcode;
    logic [7:0]            off8;
    logic [7:0]            imm8;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_W-1:0]     imm_ext;
    logic [31:0]           br_tgt;
    logic                  unused_ir_bits;

    assign opcode  = ir[31:24];
    assign off8    = ir[23:16];
    assign imm8    = ir[7:0];
    assign rd      = ir[16 +: REG_ADDR_W];
    assign rs1     = ir[8 +: REG_ADDR_W];
    assign rs2     = ir[0 +: REG_ADDR_W];
    assign imm_ext = DATA_W'($signed(imm8));
    assign br_tgt  = pc + 32'd4 + {{22{off8[7]}}, off8, 2'b00};
    assign PC      = pc;

    // SRC1 field bits above the register index carry no meaning.
    assign unused_ir_bits = ^ir[15:8+REG_ADDR_W];

    // Execute-stage ALU and next-PC selection; results are captured on the EXECUTE edge.
    always_comb begin
        res_c = '0;
        wr_c  = 1'b0;
        ill_c = 1'b0;
        npc_c = pc + 32'd4;
        case (opcode)
            8'h00: begin res_c = imm_ext;   wr_c = 1'b1; end
            8'h01: begin res_c = opb;       wr_c = 1'b1; end
            8'h02: begin res_c = opa + opb; wr_c = 1'b1; end
            8'h03: begin res_c = opa - opb; wr_c = 1'b1; end
            8'h04: begin res_c = opa & opb; wr_c = 1'b1; end
            8'h05: begin res_c = opa | opb; wr_c = 1'b1; end
            8'h06: npc_c = br_tgt;
            8'h07: if (opa == opb) npc_c = br_tgt;
`ifdef CPU_MC_MUL_EN
            8'h08: begin res_c = opa * opb; wr_c = 1'b1; end
`endif
            default: ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        IMEM_READ = 1'b0;
        RETIRE    = 1'b0;
        WB_EN     = 1'b0;
        WB_ADDR   = '0;
        WB_DATA   = '0;
        ILLEGAL   = 1'b0;
        case (state)
            FETCH: begin
                IMEM_READ = 1'b1;
                if (!IMEM_BUSY) state_nxt = DECODE;
            end
            DECODE:  state_nxt = EXECUTE;
            EXECUTE: state_nxt = WRITEBACK;
            WRITEBACK: begin
                RETIRE  = 1'b1;
                ILLEGAL = ill_q;
                WB_EN   = wr_q;
                if (wr_q) begin
                    WB_ADDR = rd;
                    WB_DATA = res_q;
                end
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
        if (RESET) begin
            IMEM_READ = 1'b0;
            RETIRE    = 1'b0;
            WB_EN     = 1'b0;
            WB_ADDR   = '0;
            WB_DATA   = '0;
            ILLEGAL   = 1'b0;
        end
    end

    // PC and the register file only change on the WRITEBACK edge, so a reset
    // before that edge discards the instruction without side effects.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc    <= '0;
            ir    <= '0;
            npc_q <= '0;
            opa   <= '0;
            opb   <= '0;
            res_q <= '0;
            wr_q  <= 1'b0;
            ill_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!IMEM_BUSY) ir <= INSTRUCTION;
                end
                DECODE: begin
                    opa <= regs[rs1];
                    opb <= regs[rs2];
                end
                EXECUTE: begin
                    res_q <= res_c;
                    wr_q  <= wr_c;
                    ill_q <= ill_c;
                    npc_q <= npc_c;
                end
                WRITEBACK: begin
                    pc <= npc_q;
                    if (wr_q) regs[rd] <= res_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc.sv
// Scoreboard bench for cpu_mc: directed program, expected retire records queued up front,
// a negedge monitor pops one record per RETIRE and compares PC, writeback, ILLEGAL and spacing.
module tb_cpu_mc;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IMEM_BUSY = 1'b0;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        IMEM_READ;
    logic        RETIRE;
    logic        WB_EN;
    logic [2:0]  WB_ADDR;
    logic [7:0]  WB_DATA;
    logic        ILLEGAL;

    logic [31:0] pc16;
    logic        imem_read16;
    logic        retire16;
    logic        wb_en16;
    logic [2:0]  wb_addr16;
    logic [15:0] wb_data16;
    logic        illegal16;

    logic [31:0] imem [64];

    typedef struct packed {
        logic [31:0] pc;
        logic        wen;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic        ill;
        logic [3:0]  gap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_ret = 0;
    int   cyc = 0;
    int   last_ret = 0;
    logic seen16 = 1'b0;

    assign INSTRUCTION = IMEM_BUSY ? 32'hDEAD_BEEF : imem[PC[7:2]];

    cpu_mc #(.DATA_W(8), .REG_ADDR_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
        .IMEM_READ(IMEM_READ), .IMEM_BUSY(IMEM_BUSY), .RETIRE(RETIRE),
        .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .ILLEGAL(ILLEGAL)
    );

    cpu_mc #(.DATA_W(16), .REG_ADDR_W(3)) dut16 (
        .CLK(CLK), .RESET(RESET), .PC(pc16), .INSTRUCTION(32'h0005_00FF),
        .IMEM_READ(imem_read16), .IMEM_BUSY(1'b0), .RETIRE(retire16),
        .WB_EN(wb_en16), .WB_ADDR(wb_addr16), .WB_DATA(wb_data16), .ILLEGAL(illegal16)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic wen, input logic [2:0] addr,
                        input logic [7:0] data, input logic ill, input logic [3:0] gap);
        exp_t x;
        x.pc = pc; x.wen = wen; x.addr = addr; x.data = data; x.ill = ill; x.gap = gap;
        q.push_back(x);
    endtask

    // Returns one cycle into the FETCH that follows retire number k.
    task automatic wait_ret(input int k);
        for (int i = 0; i < 200 && n_ret < k; i++) @(posedge CLK);
        #1;
        if (n_ret < k) begin
            n_vec++;
            n_bad++;
            $display("FAIL retire_timeout: got %0d retires expected %0d", n_ret, k);
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (RETIRE) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_retire: got retire at pc %h expected none", PC);
            end else begin
                e = q.pop_front();
                chk("retire_pc", PC, e.pc);
                chk("wb_en", 32'(WB_EN), 32'(e.wen));
                chk("wb_addr", 32'(WB_ADDR), 32'(e.addr));
                chk("wb_data", 32'(WB_DATA), 32'(e.data));
                chk("illegal", 32'(ILLEGAL), 32'(e.ill));
                if (e.gap != 4'd0) chk("retire_gap", cyc - last_ret, 32'(e.gap));
            end
            last_ret = cyc;
            n_ret++;
        end else begin
            chk("idle_outputs", 32'({ILLEGAL, WB_EN, WB_ADDR, WB_DATA}), 32'h0);
        end
    end

    always @(negedge CLK) begin
        if (retire16 && !seen16) begin
            seen16 = 1'b1;
            chk("w16_pc", pc16, 32'h0);
            chk("w16_wb_en", 32'(wb_en16), 32'h1);
            chk("w16_wb_addr", 32'(wb_addr16), 32'h5);
            chk("w16_wb_data", 32'(wb_data16), 32'h0000_FFFF);
            chk("w16_flags", 32'({illegal16, imem_read16}), 32'h0);
        end
    end

    initial begin
        int rd_cnt;
        for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
        imem[0]  = ins(8'h00, 8'h01, 8'h00, 8'h05);
        imem[1]  = ins(8'h00, 8'h02, 8'h00, 8'h03);
        imem[2]  = ins(8'h03, 8'h03, 8'h01, 8'h02);
        imem[3]  = ins(8'h06, 8'h1C, 8'h00, 8'h00);
        imem[4]  = ins(8'h07, 8'hFE, 8'h01, 8'h02);
        imem[5]  = ins(8'h00, 8'h01, 8'h00, 8'h7F);
        imem[6]  = ins(8'h00, 8'h02, 8'h00, 8'h01);
        imem[7]  = ins(8'h02, 8'h04, 8'h01, 8'h02);
        imem[8]  = ins(8'h03, 8'h07, 8'h02, 8'h01);
        imem[9]  = ins(8'h04, 8'h05, 8'h04, 8'h01);
        imem[10] = ins(8'h05, 8'h05, 8'h04, 8'h01);
        imem[11] = ins(8'h01, 8'h06, 8'h00, 8'h05);
        imem[12] = ins(8'h00, 8'h00, 8'h00, 8'h80);
        imem[13] = ins(8'h00, 8'h01, 8'h00, 8'h06);
        imem[14] = ins(8'h00, 8'h02, 8'h00, 8'h07);
        imem[15] = ins(8'h08, 8'h03, 8'h01, 8'h02);
        imem[16] = ins(8'h02, 8'h01, 8'h01, 8'h01);
        imem[17] = ins(8'h01, 8'h02, 8'h00, 8'h01);
        imem[18] = ins(8'h00, 8'h03, 8'h00, 8'h11);
        imem[19] = ins(8'hFF, 8'h03, 8'h00, 8'h00);
        imem[20] = ins(8'h00, 8'h01, 8'h00, 8'h02);
        imem[21] = ins(8'h00, 8'h02, 8'h00, 8'h03);
        imem[22] = ins(8'h02, 8'h06, 8'h01, 8'h02);
        imem[32] = ins(8'h00, 8'h01, 8'h00, 8'h09);
        imem[33] = ins(8'h00, 8'h02, 8'h00, 8'h09);
        imem[34] = ins(8'h06, 8'hE1, 8'h00, 8'h00);

        //        pc         wen   addr  data   ill   gap
        push(32'h00, 1'b1, 3'd1, 8'h05, 1'b0, 4'd0);
        push(32'h04, 1'b1, 3'd2, 8'h03, 1'b0, 4'd4);
        push(32'h08, 1'b1, 3'd3, 8'h02, 1'b0, 4'd4);
        push(32'h0C, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4);
        push(32'h80, 1'b1, 3'd1, 8'h09, 1'b0, 4'd4);
        push(32'h84, 1'b1, 3'd2, 8'h09, 1'b0, 4'd4);
        push(32'h88, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4);
        push(32'h10, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4);
        push(32'h0C, 1'b1, 3'd2, 8'h08, 1'b0, 4'd4);
        push(32'h10, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4);
        push(32'h14, 1'b1, 3'd1, 8'h7F, 1'b0, 4'd4);
        push(32'h18, 1'b1, 3'd2, 8'h01, 1'b0, 4'd4);
        push(32'h1C, 1'b1, 3'd4, 8'h80, 1'b0, 4'd4);
        push(32'h20, 1'b1, 3'd7, 8'h82, 1'b0, 4'd4);
        push(32'h24, 1'b1, 3'd5, 8'h00, 1'b0, 4'd4);
        push(32'h28, 1'b1, 3'd5, 8'hFF, 1'b0, 4'd4);
        push(32'h2C, 1'b1, 3'd6, 8'hFF, 1'b0, 4'd4);
        push(32'h30, 1'b1, 3'd0, 8'h80, 1'b0, 4'd4);
        push(32'h34, 1'b1, 3'd1, 8'h06, 1'b0, 4'd4);
        push(32'h38, 1'b1, 3'd2, 8'h07, 1'b0, 4'd4);
`ifdef CPU_MC_MUL_EN
        push(32'h3C, 1'b1, 3'd3, 8'h2A, 1'b0, 4'd4);
`else
        push(32'h3C, 1'b0, 3'd0, 8'h00, 1'b1, 4'd4);
`endif
        push(32'h40, 1'b1, 3'd1, 8'h0C, 1'b0, 4'd4);
        push(32'h44, 1'b1, 3'd2, 8'h0C, 1'b0, 4'd4);
        push(32'h48, 1'b1, 3'd3, 8'h11, 1'b0, 4'd7);
        push(32'h4C, 1'b0, 3'd0, 8'h00, 1'b1, 4'd4);
        push(32'h50, 1'b1, 3'd1, 8'h02, 1'b0, 4'd4);
        push(32'h54, 1'b1, 3'd2, 8'h03, 1'b0, 4'd4);

        repeat (2) @(negedge CLK);
        chk("rst_pc", PC, 32'h0);
        chk("rst_imem_read", 32'(IMEM_READ), 32'h0);
        chk("rst_retire", 32'(RETIRE), 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("first_fetch_read", 32'(IMEM_READ), 32'h1);

        // After the forward jump, 0x0C becomes LOADI r2,8 so the second BEQ falls through.
        wait_ret(4);
        imem[3] = ins(8'h00, 8'h02, 8'h00, 8'h08);

        wait_ret(23);
        IMEM_BUSY = 1'b1;
        rd_cnt = 0;
        fork
            begin
                repeat (3) @(posedge CLK);
                #1 IMEM_BUSY = 1'b0;
            end
            begin
                repeat (6) begin
                    @(negedge CLK);
                    if (IMEM_READ) rd_cnt++;
                end
            end
        join
        chk("busy_imem_read_cycles", rd_cnt, 32'd4);

        // Reset lands in the EXECUTE cycle of ADD r6.
        wait_ret(27);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        #1;
        chk("midrst_imem_read", 32'(IMEM_READ), 32'h0);
        chk("midrst_pc", PC, 32'h0);
        imem[0] = ins(8'h01, 8'h07, 8'h00, 8'h06);
        push(32'h00, 1'b1, 3'd7, 8'h00, 1'b0, 4'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("release_imem_read", 32'(IMEM_READ), 32'h1);
        chk("release_pc", PC, 32'h0);

        wait_ret(28);
        repeat (2) @(negedge CLK);
        chk("queue_drained", q.size(), 32'h0);
        chk("w16_retired", 32'(seen16), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
